descaler: RTL and testbench

//  Inverse of the input range-normaliser in the approximation datapath. Takes the

---
 rtl/descaler.sv | 122 ++++++++++++
 tb/tb_descaler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/descaler.sv
// +-----------------------------------------------------------------------------
// | Module      : descaler
// | Description : Undoes the input range normaliser, y_o = y_i * 2^(r - l),
// |               one bit-shift per clock behind a start/busy/done handshake.
// |               Optional define DESCALER_SAT_EN saturates on left-shift overflow.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module descaler #(
  parameter int W  = 16,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [W-1:0]  y_i,
  input  logic [SW-1:0] shift_l_i,
  input  logic [SW-1:0] shift_r_i,
  output logic [W-1:0]  y_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          ovf_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic signed [SW:0] c_one = (SW+1)'(1);

  state_t               r_state;
  logic signed [W-1:0]  r_acc;
  logic signed [SW:0]   r_net;

  logic signed [SW:0]   w_net_start;
  logic signed [W-1:0]  w_acc_nxt;
  logic signed [SW:0]   w_net_nxt;
  logic                 w_ovf;

  assign w_net_start = $signed({1'b0, shift_r_i}) - $signed({1'b0, shift_l_i});

  // Next shift step; positive net multiplies, negative net divides (floor).
  always_comb begin
    w_acc_nxt = r_acc;
    w_net_nxt = r_net;
    w_ovf     = 1'b0;
    if (r_net != '0) begin
      if (r_net[SW]) begin
        w_acc_nxt = r_acc >>> 1;
        w_net_nxt = r_net + c_one;
      end else begin
        w_acc_nxt = r_acc <<< 1;
        w_net_nxt = r_net - c_one;
`ifdef DESCALER_SAT_EN
        w_ovf     = r_acc[W-1] ^ r_acc[W-2];
`endif
      end
    end
`ifdef DESCALER_SAT_EN
    if (w_ovf) begin
      w_acc_nxt = r_acc[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      w_net_nxt = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_net   <= '0;
      y_o     <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_acc <= y_i;
            r_net <= w_net_start;
            ovf_o <= 1'b0;
            if (w_net_start == '0) begin
              r_state <= S_DONE;
              done_o  <= 1'b1;
              y_o     <= y_i;
            end else begin
              r_state <= S_SHIFT;
              busy_o  <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          r_acc <= w_acc_nxt;
          r_net <= w_net_nxt;
          if (w_ovf) ovf_o <= 1'b1;
          // Result is published on the same edge that enters DONE.
          if (w_net_nxt == '0) begin
            r_state <= S_DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            y_o     <= w_acc_nxt;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_descaler.sv
// Self-checking bench for descaler: vector table, corner sequences, random ops vs model.
`default_nettype none

module tb_descaler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] y_i = '0;
  logic [2:0]  shift_l_i = '0;
  logic [2:0]  shift_r_i = '0;
  logic [15:0] y_o;
  logic        busy_o;
  logic        done_o;
  logic        ovf_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  descaler #(.W(16), .SW(3)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .y_i(y_i),
    .shift_l_i(shift_l_i), .shift_r_i(shift_r_i),
    .y_o(y_o), .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] y;
    logic [2:0]  l;
    logic [2:0]  r;
    logic [15:0] ey;
    logic        eovf;
    int          elat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: value times 2^(r-l) with integer arithmetic; saturation at the
  // first power of two whose product leaves the signed 16-bit range.
  task automatic model(input logic [15:0] y, input int l, input int r,
                       output logic [15:0] ey, output logic eovf, output int elat);
    int     net;
    longint v;
    longint p;
    net  = r - l;
    v    = longint'($signed(y));
    eovf = 1'b0;
    if (net < 0) begin
      ey   = 16'(v >>> (-net));
      elat = -net + 1;
    end else begin
      ey   = 16'(v * (longint'(1) << net));
      elat = net + 1;
`ifdef DESCALER_SAT_EN
      for (int k = 1; k <= net; k++) begin
        p = v * (longint'(1) << k);
        if (p > 32767 || p < -32768) begin
          ey   = (v < 0) ? 16'h8000 : 16'h7FFF;
          eovf = 1'b1;
          elat = k + 1;
          break;
        end
      end
`else
      p = 0;
      if (p != 0) eovf = 1'b1;
`endif
    end
  endtask

  task automatic run_op(input string name, input logic [15:0] y, input logic [2:0] l,
                        input logic [2:0] r, input logic [15:0] ey, input logic eovf,
                        input int elat);
    logic [15:0] prev;
    int t, lat, bc;
    bit seen;
    @(negedge clk);
    prev = y_o;
    y_i = y; shift_l_i = l; shift_r_i = r; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    t = cyc;
    lat = -1; bc = 0; seen = 0;
    while (!seen && (cyc - t) < 20) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1;
        lat = cyc - t + 1;
      end else begin
        if (busy_o) bc++;
        if (y_o !== prev) check({name, " y_o held during shift"}, y_o, prev);
      end
    end
    check({name, " latency"}, lat, elat);
    check({name, " y_o"}, y_o, ey);
    check({name, " ovf_o"}, ovf_o, eovf);
    check({name, " busy cycles"}, bc, elat - 1);
    @(posedge clk);
    #1;
    check({name, " done single pulse"}, done_o, 0);
    check({name, " y_o held after"}, y_o, ey);
    check({name, " ovf_o sticky"}, ovf_o, eovf);
  endtask

  initial begin
    logic [15:0] ry, ey;
    logic [2:0]  rl, rr;
    logic        eovf;
    int          elat, t, extra;
    bit          seen;

    vecs[0]  = '{16'h1000, 3'd0, 3'd2, 16'h4000, 1'b0, 3};
    vecs[1]  = '{16'hF000, 3'd3, 3'd0, 16'hFE00, 1'b0, 4};
    vecs[2]  = '{16'h1234, 3'd0, 3'd0, 16'h1234, 1'b0, 1};
    vecs[3]  = '{16'h1234, 3'd5, 3'd5, 16'h1234, 1'b0, 1};
    vecs[4]  = '{16'h1000, 3'd2, 3'd3, 16'h2000, 1'b0, 2};
    vecs[5]  = '{16'hFFFF, 3'd1, 3'd0, 16'hFFFF, 1'b0, 2};
    vecs[6]  = '{16'h0001, 3'd0, 3'd7, 16'h0080, 1'b0, 8};
    vecs[7]  = '{16'h8000, 3'd7, 3'd0, 16'hFF00, 1'b0, 8};
`ifdef DESCALER_SAT_EN
    vecs[8]  = '{16'h3000, 3'd0, 3'd2, 16'h7FFF, 1'b1, 3};
    vecs[9]  = '{16'h4000, 3'd0, 3'd3, 16'h7FFF, 1'b1, 2};
    vecs[10] = '{16'hA000, 3'd0, 3'd1, 16'h8000, 1'b1, 2};
`else
    vecs[8]  = '{16'h3000, 3'd0, 3'd2, 16'hC000, 1'b0, 3};
    vecs[9]  = '{16'h4000, 3'd0, 3'd3, 16'h0000, 1'b0, 4};
    vecs[10] = '{16'hA000, 3'd0, 3'd1, 16'h4000, 1'b0, 2};
`endif
    vecs[11] = '{16'h0001, 3'd1, 3'd0, 16'h0000, 1'b0, 2};

    #2;
    check("reset y_o", y_o, 0);
    check("reset busy_o", busy_o, 0);
    check("reset done_o", done_o, 0);
    check("reset ovf_o", ovf_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].y, vecs[i].l, vecs[i].r,
             vecs[i].ey, vecs[i].eovf, vecs[i].elat);

    // start held through the DONE cycle must be ignored
    @(negedge clk);
    y_i = 16'h1111; shift_l_i = 3'd0; shift_r_i = 3'd0; start_i = 1'b1;
    @(posedge clk);
    #1 y_i = 16'h2222; shift_r_i = 3'd1;
    @(posedge clk);
    #1 start_i = 1'b0;
    @(negedge clk);
    check("start in DONE: done_o", done_o, 0);
    check("start in DONE: busy_o", busy_o, 0);
    check("start in DONE: y_o", y_o, 16'h1111);

    // second start while shifting is dropped
    @(negedge clk);
    y_i = 16'h0800; shift_l_i = 3'd7; shift_r_i = 3'd0; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    t = cyc;
    @(posedge clk);
    #1 begin y_i = 16'h1000; shift_l_i = 3'd0; start_i = 1'b1; end
    @(posedge clk);
    #1 start_i = 1'b0;
    seen = 0; elat = -1;
    while (!seen && (cyc - t) < 20) begin
      @(negedge clk);
      if (done_o) begin seen = 1; elat = cyc - t + 1; end
    end
    check("ignored start: latency", elat, 8);
    check("ignored start: y_o", y_o, 16'h0010);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_o || busy_o) extra++;
    end
    check("ignored start: no second op", extra, 0);

    // reset mid-shift aborts
    @(negedge clk);
    y_i = 16'h0100; shift_l_i = 3'd6; shift_r_i = 3'd0; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    t = cyc;
    while ((cyc - t) < 3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort y_o", y_o, 0);
    check("abort busy_o", busy_o, 0);
    check("abort done_o", done_o, 0);
    check("abort ovf_o", ovf_o, 0);
    @(negedge clk) rst = 1'b0;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_o) extra++;
    end
    check("abort no done", extra, 0);
    run_op("after abort", 16'h0100, 3'd6, 3'd0, 16'h0004, 1'b0, 7);

    for (int i = 0; i < 150; i++) begin
      ry = 16'($urandom);
      if (i % 3 == 0) ry = 16'($signed(ry) >>> $urandom_range(4, 12));
      rl = 3'($urandom_range(0, 7));
      rr = 3'($urandom_range(0, 7));
      model(ry, int'(rl), int'(rr), ey, eovf, elat);
      run_op($sformatf("rand%0d", i), ry, rl, rr, ey, eovf, elat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
